// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter: shifts the operand one bit per clock, logical or
// arithmetic, with start/ready handshake, one-cycle done pulse and flush abort.
module shift_right_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] shift_in,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shifted_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SHW-1:0]   cnt_q,   cnt_d;
  logic             mode_q,  mode_d;
  logic             accept;

  assign accept = (state_q == S_IDLE) && start && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the datapath registers are reset too because
  // shifted_out is architecturally visible and must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (start) state_d = (shamt == '0) ? S_DONE : S_SHIFT;
        S_SHIFT: if (cnt_q <= SHW'(1)) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: load on accept, one-bit shift per SHIFT cycle; flush freezes it.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (accept) begin
      data_d = shift_in;
      cnt_d  = shamt;
      mode_d = arith;
    end else if (state_q == S_SHIFT && !flush && cnt_q != '0) begin
      data_d = {mode_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
      cnt_d  = cnt_q - SHW'(1);
    end
  end

  // A flush landing on the DONE cycle suppresses that cycle's pulse.
  always_comb begin
    ready = (state_q == S_IDLE);
    busy  = (state_q == S_SHIFT);
    done  = (state_q == S_DONE) && !flush;
  end

  assign shifted_out = data_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: expected results are queued at accept
// and popped when done is observed.
module tb_shift_right_seq;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] shift_in;
  logic [SHW-1:0]   shamt;
  logic             arith;
  logic             flush;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] shifted_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q[$];

  shift_right_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .shift_in    (shift_in),
    .shamt       (shamt),
    .arith       (arith),
    .flush       (flush),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .shifted_out (shifted_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d,
                                             input logic [SHW-1:0] s,
                                             input logic a);
    logic signed [WIDTH-1:0] sd;
    sd = d;
    return a ? WIDTH'(sd >>> s) : (d >> s);
  endfunction

  // Drive a request during an IDLE cycle; returns right at the accepting edge.
  task automatic accept_op(input logic [WIDTH-1:0] d, input logic [SHW-1:0] s,
                           input logic a);
    @(negedge clk);
    check("ready_before_accept", {31'd0, ready}, 32'd1);
    start    = 1'b1;
    shift_in = d;
    shamt    = s;
    arith    = a;
    @(posedge clk);
    exp_q.push_back(model(d, s, a));
  endtask

  // Walk cycles 1..lat after accept, then the following IDLE cycle.
  task automatic wait_done(input int lat, input bit keep, input int glitch);
    logic [WIDTH-1:0] e;
    for (int c = 1; c <= lat; c++) begin
      #1;
      if (!keep) start = 1'b0;
      if (c == glitch) begin
        start    = 1'b1;
        shift_in = $urandom;
        shamt    = SHW'($urandom_range(0, 31));
        arith    = ~arith;
      end
      check($sformatf("busy_c%0d", c), {31'd0, busy}, {31'd0, (c < lat)});
      check($sformatf("done_c%0d", c), {31'd0, done}, {31'd0, (c == lat)});
      if (c == lat) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", shifted_out, e);
        end
      end
      @(posedge clk);
    end
    #1;
    if (!keep) start = 1'b0;
    check("ready_after_done", {31'd0, ready}, 32'd1);
    check("no_done_after", {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    shift_in = '0;
    shamt    = '0;
    arith    = 1'b0;
    #12;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_data", shifted_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Logical and arithmetic shift of the sign bit by 4
    accept_op(32'h8000_0000, 5'd4, 1'b0);
    wait_done(5, 1'b0, 0);
    check("lsr4_const", shifted_out, 32'h0800_0000);
    accept_op(32'h8000_0000, 5'd4, 1'b1);
    wait_done(5, 1'b0, 0);
    check("asr4_const", shifted_out, 32'hF800_0000);
    check("hold_after_done", shifted_out, 32'hF800_0000);

    // Maximum shift amount
    accept_op(32'h8000_0000, 5'd31, 1'b1);
    wait_done(32, 1'b0, 0);
    check("asr31_const", shifted_out, 32'hFFFF_FFFF);

    // Zero shift: straight to DONE
    accept_op(32'h1234_5678, 5'd0, 1'b0);
    wait_done(1, 1'b0, 0);
    check("sh0_const", shifted_out, 32'h1234_5678);

    // start with new operands mid-operation is ignored
    accept_op(32'h0000_FF00, 5'd8, 1'b0);
    wait_done(9, 1'b0, 3);
    check("ignore_start_const", shifted_out, 32'h0000_00FF);

    // Flush in cycle 2 of a 10-bit shift
    accept_op(32'hFFFF_0000, 5'd10, 1'b0);
    #1 start = 1'b0;
    @(posedge clk);
    #1 flush = 1'b1;
    check("flush_c2_data", shifted_out, 32'h7FFF_8000);
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_ready", {31'd0, ready}, 32'd1);
    check("flush_hold", shifted_out, 32'h7FFF_8000);
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      check("flush_no_done", {31'd0, done}, 32'd0);
      @(posedge clk);
      #1;
    end
    accept_op(32'h0000_0002, 5'd1, 1'b0);
    wait_done(2, 1'b0, 0);
    check("post_flush_const", shifted_out, 32'h0000_0001);

    // start and flush together in IDLE: no accept
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("start_flush_ready", {31'd0, ready}, 32'd1);
    check("start_flush_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in cycle 3 of a 6-bit shift
    accept_op(32'hABCD_0000, 5'd6, 1'b1);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_data", shifted_out, 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 check("rst_no_done", {31'd0, done}, 32'd0);
    end
    accept_op(32'hABCD_0000, 5'd6, 1'b1);
    wait_done(7, 1'b0, 0);
    check("post_rst_const", shifted_out, 32'hFEAF_3400);

    // Back-to-back with start held high: second accept shamt+2 edges later
    accept_op(32'hC000_0001, 5'd2, 1'b1);
    #1;
    shift_in = 32'h0F0F_0F0F;
    shamt    = 5'd3;
    arith    = 1'b0;
    wait_done(3, 1'b1, 0);
    exp_q.push_back(model(32'h0F0F_0F0F, 5'd3, 1'b0));
    @(posedge clk);
    wait_done(4, 1'b0, 0);
    check("b2b_const", shifted_out, 32'h01E1_E1E1);

    // Random operands against the reference model
    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] d;
      logic [SHW-1:0]   s;
      logic             a;
      d = $urandom;
      s = SHW'($urandom_range(0, 31));
      a = 1'($urandom_range(0, 1));
      accept_op(d, s, a);
      wait_done(int'(s) + 1, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_right_seq.md
SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data width in bits.
REQ-002 The block SHALL have parameter SHW, default 5: shift-amount width, with 2^SHW >= WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request; accepted only when ready=1.
REQ-006 The block SHALL have port shift_in, input, WIDTH bits: operand, sampled on accept.
REQ-007 The block SHALL have port shamt, input, SHW bits: shift amount, sampled on accept.
REQ-008 The block SHALL have port arith, input, 1 bit: 1 = arithmetic (sign fill), 0 = logical (zero fill); sampled on accept.
REQ-009 The block SHALL have port flush, input, 1 bit: synchronous abort.
REQ-010 The block SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-011 The block SHALL have port busy, output, 1 bit: high in SHIFT.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-013 The block SHALL have port shifted_out, output, WIDTH bits: result register.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE, encoded in a registered state variable.
REQ-015 Accept SHALL occur when state=IDLE, start=1 and flush=0: load the data register with shift_in, the count with shamt, and the mode flag with arith.
REQ-016 On accept with shamt=0, the next state SHALL be DONE; otherwise it SHALL be SHIFT.
REQ-017 In SHIFT, each cycle SHALL shift the data register right by 1 bit, with MSB fill = mode flag AND current MSB; the count SHALL decrement by 1.
REQ-018 In SHIFT, when count=1 before decrement, the next state SHALL be DONE; otherwise the state SHALL remain SHIFT.
REQ-019 In DONE, done=1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-020 Latency: done SHALL be high in the (shamt+1)-th cycle after the accepting edge; shamt=0 gives 1 cycle and shamt=31 gives 32 cycles.
REQ-021 shifted_out SHALL equal the data register at all times and SHALL hold its value after DONE until the next accept.
REQ-022 The final result SHALL equal shift_in >> shamt (logical) or shift_in >>> shamt (arithmetic, sign of shift_in[WIDTH-1]).
REQ-023 start while state != IDLE SHALL be ignored; operand inputs SHALL be don't-care outside accept.
REQ-024 Changes to shift_in, shamt or arith after accept SHALL NOT affect an in-flight operation.
REQ-025 flush=1 in any state SHALL force next state IDLE with no done pulse, leave shifted_out holding its current value, and take priority over start.
REQ-026 start and flush asserted together in IDLE SHALL NOT accept the request.
REQ-027 Back-to-back operation: start may be held high; the next accept SHALL occur in the IDLE cycle following DONE, giving a minimum issue interval of shamt+2 cycles.
REQ-028 No arithmetic overflow SHALL be possible; the count SHALL never underflow below 0.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE, data register=0, count=0, mode=0, done=0, busy=0, ready=1 and shifted_out=0.
REQ-030 Reset asserted mid-operation SHALL abort the operation without a done pulse; the first accept after rst_n rises SHALL behave as from power-up.
REQ-031 Deassertion of rst_n SHALL take effect on the next rising edge of clk; start coincident with that edge MAY be accepted.

Verification
REQ-032 shift_in=0x80000000, shamt=4, arith=0 -> done in cycle 5 after accept, shifted_out=0x08000000, busy high in cycles 1-4.
REQ-033 Same operand with arith=1 -> shifted_out=0xF8000000 at done in cycle 5; shift_in=0x80000000, shamt=31, arith=1 -> 0xFFFFFFFF at cycle 32.
REQ-034 shift_in=0x12345678, shamt=0 -> no busy cycle, done in cycle 1, shifted_out=0x12345678.
REQ-035 Accept shamt=8 with shift_in=0x0000FF00; pulse start with different operands in cycle 3 -> ignored; result 0x000000FF at cycle 9.
REQ-036 flush in cycle 2 of a shamt=10 operation -> ready=1 next cycle, no done pulse; a subsequent shamt=1 op on 0x2 -> 0x1 at done.
REQ-037 rst_n=0 in cycle 3 of a shamt=6 operation -> outputs at reset values immediately; no done pulse; a clean operation after release is correct.
